axi4_burst_addr_gen: RTL

Parametrised AXI4 burst address and strobe generator for the master and slave BFM data paths. It accepts one address-channel request (id, addr, len, size, burst), then emits len+1 beat descriptors through a valid/ready handshake. Each descriptor carries the beat address, the byte-lane strobe, the beat index and a last flag, with FIXED, INCR and WRAP arithmetic computed per the AXI4 rules. Protocol violations in the request are flagged and held for the whole burst, so downstream logic can return SLVERR while still consuming the full beat count.

---
 rtl/axi4_burst_addr_gen.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/axi4_burst_addr_gen.sv
// AXI4 burst address/strobe generator: accepts one address-channel request and
// emits len+1 beat descriptors (address, strobe, index, last, error flags).
module axi4_burst_addr_gen #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ID_WIDTH      = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ID_WIDTH-1:0]       req_id,
  input  logic [ADDRESS_WIDTH-1:0]  req_addr,
  input  logic [7:0]                req_len,
  input  logic [2:0]                req_size,
  input  logic [1:0]                req_burst,
  output logic                      beat_valid,
  input  logic                      beat_ready,
  output logic [ID_WIDTH-1:0]       beat_id,
  output logic [ADDRESS_WIDTH-1:0]  beat_addr,
  output logic [DATA_WIDTH/8-1:0]   beat_strb,
  output logic [7:0]                beat_idx,
  output logic                      beat_last,
  output logic [3:0]                beat_err
);

  localparam int AW      = ADDRESS_WIDTH;
  localparam int NB      = DATA_WIDTH / 8;
  localparam int NB_LOG2 = $clog2(NB);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic {S_IDLE, S_BURST} state_e;

  state_e                state_q, state_d;
  logic                  ready_q, ready_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [7:0]            idx_q, idx_d;
  logic [3:0]            err_q, err_d;

  // Next-beat address arithmetic on the current beat.
  logic [AW-1:0] bytes_w, aligned_cur, incr_next, wrap_bytes, wrap_lower, wrap_next, step_addr;

  always_comb begin
    bytes_w     = AW'(1) << size_q;
    aligned_cur = addr_q & ~(bytes_w - AW'(1));
    incr_next   = aligned_cur + bytes_w;
    wrap_bytes  = bytes_w * (AW'(len_q) + AW'(1));
    wrap_lower  = addr_q & ~(wrap_bytes - AW'(1));
    wrap_next   = (incr_next == wrap_lower + wrap_bytes) ? wrap_lower : incr_next;
    if (burst_q == BURST_FIXED) begin
      step_addr = addr_q;
    end else if (burst_q == BURST_WRAP && !err_q[1]) begin
      step_addr = wrap_next;
    end else begin
      step_addr = incr_next;
    end
  end

  // Request checks; the 4KB test runs one bit wider so a top-of-memory wrap counts as a crossing.
  logic [AW-1:0] req_bytes, req_aligned;
  logic [AW:0]   req_span, req_end;
  logic          req_cross;
  logic [3:0]    req_err;

  always_comb begin
    req_bytes   = AW'(1) << req_size;
    req_aligned = req_addr & ~(req_bytes - AW'(1));
    req_span    = ((AW+1)'(req_len) + (AW+1)'(1)) << req_size;
    req_end     = {1'b0, req_aligned} + req_span - (AW+1)'(1);
    req_cross   = (req_end[AW:12] != {1'b0, req_addr[AW-1:12]});
    req_err[0]  = (req_burst == BURST_RSVD);
    req_err[1]  = (req_burst == BURST_WRAP) &&
                  !((req_len == 8'd1) || (req_len == 8'd3) || (req_len == 8'd7) || (req_len == 8'd15));
    req_err[2]  = (int'(req_size) > NB_LOG2);
    req_err[3]  = (req_burst == BURST_INCR) && req_cross;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      idx_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    idx_d   = idx_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          id_d    = req_id;
          addr_d  = req_addr;
          len_d   = req_len;
          size_d  = req_size;
          burst_d = req_burst;
          idx_d   = '0;
          err_d   = req_err;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (beat_ready) begin
          if (idx_q == len_q) begin
            state_d = S_IDLE;
          end else begin
            addr_d = step_addr;
            idx_d  = idx_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Registered so there is no combinational path from beat_ready.
    ready_d = (state_d == S_IDLE);
  end

  // Byte lanes lo..hi of the beat, with lo taken from the possibly unaligned address.
  logic [AW-1:0] lo_w, hi_w;
  logic [NB-1:0] lane_on;

  assign lo_w = addr_q & AW'(NB - 1);
  assign hi_w = (aligned_cur & AW'(NB - 1)) + bytes_w - AW'(1);

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign lane_on[gi] = (AW'(gi) >= lo_w) && (AW'(gi) <= hi_w);
    end
  endgenerate

  assign req_ready  = ready_q;
  assign beat_valid = (state_q == S_BURST);
  assign beat_id    = id_q;
  assign beat_addr  = addr_q;
  assign beat_idx   = idx_q;
  assign beat_err   = err_q;
  assign beat_last  = beat_valid && (idx_q == len_q);
  assign beat_strb  = (beat_valid && (err_q == 4'b0000)) ? lane_on : '0;

endmodule
